// File: rtl/johnson_pkg.sv
// ---------------------------------------------------------------------------
// johnson_pkg
// Shared types and constants for the Johnson sequence controller.
//   state_t  : controller FSM encoding
//   DIR_FWD  : forward shift direction
//   DIR_REV  : reverse shift direction
// ---------------------------------------------------------------------------
package johnson_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/johnson_core.sv
// ---------------------------------------------------------------------------
// johnson_core
// N-bit Johnson shift register with legality check and one-hot phase decode.
// An illegal register value is replaced by all-zero on the next edge,
// whatever the enable says.
//
// Ports
//   c        in   clock, rising edge
//   r        in   asynchronous active-low reset
//   en       in   shift one position on this edge
//   dir      in   shift direction (DIR_FWD / DIR_REV)
//   q        out  register value
//   phase    out  one-hot position, all zero while q is illegal
//   illegal  out  q is not one of the 2N Johnson states
// ---------------------------------------------------------------------------
module johnson_core
    import johnson_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           c,
    input  logic           r,
    input  logic           en,
    input  logic           dir,
    output logic [N-1:0]   q,
    output logic [2*N-1:0] phase,
    output logic           illegal
);

    localparam int IDX_W = $clog2(2 * N);

    logic [N-1:0]     q_reg;
    logic [IDX_W-1:0] ones;
    logic [IDX_W-1:0] edges;
    logic [IDX_W-1:0] idx;

    assign q = q_reg;

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            q_reg <= '0;
        end else if (illegal) begin
            q_reg <= '0;
        end else if (en) begin
            if (dir == DIR_REV) begin
                q_reg <= {~q_reg[0], q_reg[N-1:1]};
            end else begin
                q_reg <= {q_reg[N-2:0], ~q_reg[N-1]};
            end
        end
    end

    // A legal Johnson word has at most one 0/1 boundary between adjacent
    // bits; exactly 2N such words exist, matching the sequence length.
    always_comb begin
        ones  = '0;
        edges = '0;
        for (int i = 0; i < N; i++) begin
            ones = ones + IDX_W'(q_reg[i]);
        end
        for (int i = 0; i < N - 1; i++) begin
            edges = edges + IDX_W'(q_reg[i] ^ q_reg[i+1]);
        end
    end

    assign illegal = (edges > IDX_W'(1));

    // Upper half of the cycle counts down from 2N; the subtraction is done
    // modulo 2^IDX_W, which is exact because the result is below 2N.
    always_comb begin
        if (q_reg[N-1]) begin
            idx = IDX_W'(2 * N) - ones;
        end else begin
            idx = ones;
        end
    end

    always_comb begin
        phase = '0;
        if (!illegal) begin
            phase[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// ---------------------------------------------------------------------------
// johnson_seq_ctrl
// Runs a Johnson register forward or backward for a requested number of
// steps, with pause (hold), abort and single-cycle completion/error pulses.
//
// State table
//   state    | meaning
//   ST_IDLE  | waiting for start; steps/dir sampled here
//   ST_RUN   | shifting once per cycle while hold is low
//   ST_PAUSE | run suspended by hold, position and count kept
//   ST_DONE  | one-cycle completion, done high
//
// Ports
//   c      in   clock, rising edge
//   r      in   asynchronous active-low reset
//   start  in   request a run (IDLE only)
//   steps  in   shift count for the run, sampled with start
//   dir    in   0 forward, 1 reverse, sampled with start
//   hold   in   pause shifting while high
//   abort  in   end the run without done, q kept
//   q      out  Johnson register value
//   phase  out  one-hot decode of the position in the sequence
//   busy   out  high in RUN or PAUSE
//   done   out  one-cycle pulse on normal completion
//   err    out  one-cycle pulse when an illegal q was recovered
// ---------------------------------------------------------------------------
module johnson_seq_ctrl
    import johnson_pkg::*;
#(
    parameter int N      = 4,
    parameter int STEP_W = 8
) (
    input  logic              c,
    input  logic              r,
    input  logic              start,
    input  logic [STEP_W-1:0] steps,
    input  logic              dir,
    input  logic              hold,
    input  logic              abort,
    output logic [N-1:0]      q,
    output logic [2*N-1:0]    phase,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state;
    logic [STEP_W-1:0] remaining;
    logic              dir_r;
    logic              core_en;
    logic              illegal;

    // Abort and hold both suppress the shift on the edge they are seen.
    assign core_en = (state == ST_RUN) && !hold && !abort;

    johnson_core #(
        .N (N)
    ) u_core (
        .c       (c),
        .r       (r),
        .en      (core_en),
        .dir     (dir_r),
        .q       (q),
        .phase   (phase),
        .illegal (illegal)
    );

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            err <= 1'b0;
        end else begin
            err <= illegal;
        end
    end

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            state     <= ST_IDLE;
            remaining <= '0;
            dir_r     <= DIR_FWD;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (steps != '0) begin
                            remaining <= steps;
                            dir_r     <= dir;
                            busy      <= 1'b1;
                            state     <= ST_RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        remaining <= '0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (hold) begin
                        state <= ST_PAUSE;
                    end else begin
                        remaining <= remaining - STEP_W'(1);
                        // The last shift and the move to DONE share an edge.
                        if (remaining <= STEP_W'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (abort) begin
                        remaining <= '0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (!hold) begin
                        state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
module tb_johnson_seq_ctrl;

    logic       c;
    logic       r;
    logic       start;
    logic [7:0] steps;
    logic       dir;
    logic       hold;
    logic       abort;
    logic [3:0] q;
    logic [7:0] phase;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    johnson_seq_ctrl #(
        .N      (4),
        .STEP_W (8)
    ) dut (
        .c     (c),
        .r     (r),
        .start (start),
        .steps (steps),
        .dir   (dir),
        .hold  (hold),
        .abort (abort),
        .q     (q),
        .phase (phase),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] eq, input logic [7:0] eph,
                              input logic eb, input logic ed, input logic ee);
        check({tag, ".q"},     32'(q),     32'(eq));
        check({tag, ".phase"}, 32'(phase), 32'(eph));
        check({tag, ".busy"},  32'(busy),  32'(eb));
        check({tag, ".done"},  32'(done),  32'(ed));
        check({tag, ".err"},   32'(err),   32'(ee));
    endtask

    logic [3:0] fwd5_q  [5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110};
    logic [7:0] fwd5_ph [5] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    logic [3:0] rev3_q  [3] = '{4'b1111, 4'b0111, 4'b0011};
    logic [7:0] rev3_ph [3] = '{8'h10, 8'h08, 8'h04};
    logic [3:0] run9_q  [6] = '{4'b1100, 4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b0111};
    logic [7:0] run9_ph [6] = '{8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08};

    initial begin
        r     = 1'b0;
        start = 1'b0;
        steps = 8'd0;
        dir   = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;

        #2;
        check_outs("reset", 4'b0000, 8'h01, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge c);
        @(negedge c);
        r = 1'b1;
        tick();
        check_outs("post_reset", 4'b0000, 8'h01, 1'b0, 1'b0, 1'b0);

        // forward run of 5
        start = 1'b1; steps = 8'd5; dir = 1'b0;
        tick();
        start = 1'b0;
        check_outs("fwd5.start", 4'b0000, 8'h01, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_outs($sformatf("fwd5.s%0d", i + 1), fwd5_q[i], fwd5_ph[i],
                       (i < 4), (i == 4), 1'b0);
        end
        tick();
        check_outs("fwd5.idle", 4'b1110, 8'h20, 1'b0, 1'b0, 1'b0);

        // reverse run of 3; start/steps/dir disturbed mid-run
        start = 1'b1; steps = 8'd3; dir = 1'b1;
        tick();
        steps = 8'd1; dir = 1'b0;
        check_outs("rev3.start", 4'b1110, 8'h20, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) start = 1'b0;
            tick();
            check_outs($sformatf("rev3.s%0d", i + 1), rev3_q[i], rev3_ph[i],
                       (i < 2), (i == 2), 1'b0);
        end
        tick();
        check_outs("rev3.idle", 4'b0011, 8'h04, 1'b0, 1'b0, 1'b0);

        // 9 steps with a 2-cycle hold after the 3rd shift
        start = 1'b1; steps = 8'd9; dir = 1'b0;
        tick();
        start = 1'b0;
        tick(); check_outs("run9.s1", 4'b0111, 8'h08, 1'b1, 1'b0, 1'b0);
        tick(); check_outs("run9.s2", 4'b1111, 8'h10, 1'b1, 1'b0, 1'b0);
        tick(); check_outs("run9.s3", 4'b1110, 8'h20, 1'b1, 1'b0, 1'b0);
        hold = 1'b1;
        tick(); check_outs("run9.pause1", 4'b1110, 8'h20, 1'b1, 1'b0, 1'b0);
        tick(); check_outs("run9.pause2", 4'b1110, 8'h20, 1'b1, 1'b0, 1'b0);
        hold = 1'b0;
        tick(); check_outs("run9.resume", 4'b1110, 8'h20, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_outs($sformatf("run9.s%0d", i + 4), run9_q[i], run9_ph[i],
                       (i < 5), (i == 5), 1'b0);
        end
        tick();
        check_outs("run9.idle", 4'b0111, 8'h08, 1'b0, 1'b0, 1'b0);

        // abort while paused
        start = 1'b1; steps = 8'd4; dir = 1'b0;
        tick();
        start = 1'b0;
        tick(); check_outs("abtp.s1", 4'b1111, 8'h10, 1'b1, 1'b0, 1'b0);
        hold = 1'b1;
        tick(); check_outs("abtp.pause", 4'b1111, 8'h10, 1'b1, 1'b0, 1'b0);
        abort = 1'b1;
        tick(); check_outs("abtp.abort", 4'b1111, 8'h10, 1'b0, 1'b0, 1'b0);
        abort = 1'b0; hold = 1'b0;
        tick(); check_outs("abtp.after", 4'b1111, 8'h10, 1'b0, 1'b0, 1'b0);

        // abort on the final step
        start = 1'b1; steps = 8'd2; dir = 1'b1;
        tick();
        start = 1'b0;
        tick(); check_outs("abtf.s1", 4'b0111, 8'h08, 1'b1, 1'b0, 1'b0);
        abort = 1'b1;
        tick(); check_outs("abtf.abort", 4'b0111, 8'h08, 1'b0, 1'b0, 1'b0);
        abort = 1'b0;
        tick(); check_outs("abtf.after", 4'b0111, 8'h08, 1'b0, 1'b0, 1'b0);

        // zero-step run
        start = 1'b1; steps = 8'd0; dir = 1'b0;
        tick(); check_outs("zero.done", 4'b0111, 8'h08, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        tick(); check_outs("zero.idle", 4'b0111, 8'h08, 1'b0, 1'b0, 1'b0);

        // illegal state recovery
        force dut.u_core.q_reg = 4'b0101;
        #1;
        check("illegal.q", 32'(q), 32'(4'b0101));
        check("illegal.phase", 32'(phase), 32'(8'h00));
        release dut.u_core.q_reg;
        tick(); check_outs("illegal.recover", 4'b0000, 8'h01, 1'b0, 1'b0, 1'b1);
        tick(); check_outs("illegal.after", 4'b0000, 8'h01, 1'b0, 1'b0, 1'b0);

        // reset in the middle of a run
        start = 1'b1; steps = 8'd6; dir = 1'b0;
        tick();
        start = 1'b0;
        tick(); check_outs("rstrun.s1", 4'b0001, 8'h02, 1'b1, 1'b0, 1'b0);
        tick(); check_outs("rstrun.s2", 4'b0011, 8'h04, 1'b1, 1'b0, 1'b0);
        #3;
        r = 1'b0;
        #1;
        check_outs("rstrun.async", 4'b0000, 8'h01, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge c);
        @(negedge c);
        r = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_outs($sformatf("rstrun.rel%0d", i), 4'b0000, 8'h01, 1'b0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/johnson_seq_ctrl.md
JOHNSON_SEQ_CTRL -- requirements
Module: johnson_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, giving the Johnson register width (2N legal states).
REQ-002 SHALL have parameter STEP_W, default 8, giving the width of the step-count input.
REQ-003 SHALL have port c, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port r, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a run; sampled only in IDLE.
REQ-006 SHALL have port steps, input, STEP_W bits: number of shifts for the run; sampled with start.
REQ-007 SHALL have port dir, input, 1 bit: 0 = forward, 1 = reverse; sampled with start.
REQ-008 SHALL have port hold, input, 1 bit: pause shifting while high.
REQ-009 SHALL have port abort, input, 1 bit: terminate the current run.
REQ-010 SHALL have port q, output, N bits: Johnson register value.
REQ-011 SHALL have port phase, output, 2N bits: one-hot decode of the q position.
REQ-012 SHALL have port busy, output, 1 bit: high in RUN or PAUSE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse on normal completion.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse on illegal-q recovery.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-016 Forward shift SHALL be q <= {q[N-2:0], ~q[N-1]}; for N=4 the sequence is 0000,0001,0011,0111,1111,1110,1100,1000, then wraps.
REQ-017 Reverse shift SHALL be q <= {~q[0], q[N-1:1]}, which traverses the forward sequence backwards.
REQ-018 IDLE: start=1 with steps!=0 SHALL latch steps into a remaining counter, latch dir, and go to RUN; start=1 with steps=0 SHALL go to DONE without shifting.
REQ-019 RUN with hold=0 SHALL shift q once per cycle and decrement remaining; the shift that brings remaining from 1 to 0 SHALL move the FSM to DONE on the same edge.
REQ-020 RUN with hold=1 SHALL go to PAUSE with no shift on that edge. PAUSE with hold=0 SHALL return to RUN with no shift on that edge.
REQ-021 abort=1 in RUN or PAUSE SHALL go to IDLE with no shift, retain q, and suppress done; abort SHALL take priority over hold and over the final step.
REQ-022 DONE SHALL last exactly one cycle, then go to IDLE; done = (state==DONE).
REQ-023 start SHALL be ignored in RUN, PAUSE and DONE; steps and dir changes during a run SHALL have no effect.
REQ-024 Latency: start sampled at edge k with steps=S>0 SHALL produce shifts at edges k+1..k+S when there is no hold, with done high for the cycle after edge k+S.
REQ-025 q SHALL NOT be cleared by start; each run continues from the current position.
REQ-026 phase index SHALL be popcount(q) when q[N-1]=0 and 2N-popcount(q) when q[N-1]=1; phase[index]=1 and all other bits 0.
REQ-027 If q is not a legal Johnson state, the next edge SHALL load q=0 and pulse err for one cycle, regardless of FSM state. While q is illegal, phase SHALL be all zero.

Reset
REQ-028 r=0 SHALL immediately force state=IDLE, q=0, remaining=0, latched dir=0, busy=0, done=0, err=0, and phase=one-hot bit 0.
REQ-029 Reset asserted mid-run SHALL abandon the run; no done SHALL follow reset release.

Structure
REQ-030 The FSM state encoding type and the forward/reverse direction constants SHALL live in the shared package johnson_pkg.
REQ-031 The shift register, illegal-state check and phase decode SHALL be the sub-module johnson_core (ports: c, r, en, dir, q, phase, illegal); johnson_seq_ctrl SHALL hold the FSM and the remaining counter.

Verification
REQ-032 Reset, then start with steps=5, dir=0 -> q goes 0001, 0011, 0111, 1111, 1110 on consecutive edges; done high for 1 cycle after the 5th shift; busy low in that cycle.
REQ-033 From q=1110, start with steps=3, dir=1 -> q goes 1111, 0111, 0011; phase goes 4, 3, 2.
REQ-034 steps=9, dir=0, hold high for 2 cycles after the 3rd shift -> exactly 9 shifts total, done delayed by 3 cycles, and q wraps past 1000 to 0000 to 0001.
REQ-035 abort during PAUSE and again on the final-step cycle -> IDLE, q unchanged on that edge, no done pulse.
REQ-036 start with steps=0 -> done pulse on the next cycle, q unchanged; start asserted while busy -> ignored.
REQ-037 Force q=0101 -> q=0000 and an err pulse on the next edge; r=0 mid-run -> all outputs at reset values asynchronously.
